// File: rtl/aqed_fifo_dut.sv
// aqed_fifo_dut: single-clock FIFO checked by the A-QED monitor.
// Registered read data with 1-cycle latency, plus an empty-FIFO bypass that
// returns a simultaneously written word without storing it.
module aqed_fifo_dut #(
  parameter  int DATA_WIDTH = 16,
  parameter  int DEPTH      = 64,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic                  wen_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  ren_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  empty,
  output logic                  full,
  output logic [AW:0]           count
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;

  logic w_empty;
  logic w_full;
  logic w_wa;
  logic w_ra;
  logic w_bypass;
  logic w_store;
  logic w_rd;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));

  // Accept terms; a bypass is a write accept that never reaches memory.
  assign w_wa     = wen_in & ~w_full & ~flush;
  assign w_ra     = ren_in & ~flush & (~w_empty | wen_in);
  assign w_bypass = w_empty & wen_in & ren_in & ~flush;
  assign w_store  = w_wa & ~w_bypass;
  assign w_rd     = w_ra & ~w_empty;

  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_count;
  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;

  // Storage array: written only for words that are actually buffered.
  always_ff @(posedge clk) begin
    if (!reset && clk_en && w_store) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy and registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_valid_out <= 1'b0;
      end else begin
        r_valid_out <= w_ra;
        if (w_rd) begin
          r_data_out <= r_mem[r_rd_ptr];
          r_rd_ptr   <= r_rd_ptr + AW'(1);
        end else if (w_bypass) begin
          r_data_out <= data_in;
        end
        if (w_store) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        case ({w_store, w_rd})
          2'b10:   r_count <= r_count + (AW+1)'(1);
          2'b01:   r_count <= r_count - (AW+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aqed_fifo_dut.sv
// Self-checking bench for aqed_fifo_dut: a queue model acts as scoreboard,
// pushing written words and popping them as expected read results.
module tb_aqed_fifo_dut;
  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          reset;
  logic          clk_en;
  logic          flush;
  logic          wen_in;
  logic [DW-1:0] data_in;
  logic          ren_in;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          empty;
  logic          full;
  logic [AW:0]   count;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_dout;
  logic          exp_valid;
  int            exp_count;

  aqed_fifo_dut #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush),
    .wen_in(wen_in), .data_in(data_in), .ren_in(ren_in),
    .data_out(data_out), .valid_out(valid_out),
    .empty(empty), .full(full), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle, update the scoreboard, sample 1 time unit after the edge.
  task automatic drive(input bit rst, input bit en, input bit f,
                       input bit w, input bit r, input logic [DW-1:0] d);
    int  pre;
    bit  ra, byp;
    reset = rst; clk_en = en; flush = f; wen_in = w; ren_in = r; data_in = d;
    if (rst) begin
      mq.delete(); exp_dout = '0; exp_valid = 1'b0;
    end else if (en) begin
      if (f) begin
        mq.delete(); exp_valid = 1'b0;
      end else begin
        pre = mq.size();
        ra  = r && (pre > 0 || w);
        byp = (pre == 0) && w && r;
        if (ra) exp_dout = byp ? d : mq.pop_front();
        if (w && pre < DEPTH && !byp) mq.push_back(d);
        exp_valid = ra;
      end
    end
    exp_count = mq.size();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 0, 0, '0);
    drive(1, 0, 1, 1, 1, 16'hFFFF);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, '0);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", full); end
    total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", valid_out); end
    total++; if (data_out !== '0) begin bad++; $display("FAIL reset_dout got=%h exp=0000", data_out); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      drive(0, 1, 0, 1, 0, DW'(i));
      total++; if (count !== (AW+1)'(exp_count)) begin bad++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, exp_count); end
    end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%0b exp=1", full); end
    drive(0, 1, 0, 1, 0, 16'hBEEF);
    total++; if (count !== 7'd64) begin bad++; $display("FAIL overflow_count got=%0d exp=64", count); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL overflow_full got=%0b exp=1", full); end
    for (int i = 1; i <= DEPTH; i++) begin
      drive(0, 1, 0, 0, 1, '0);
      total++; if (valid_out !== 1'b1 || data_out !== exp_dout || exp_dout !== DW'(i)) begin
        bad++; $display("FAIL drain_data i=%0d got=%b/%h exp=1/%h", i, valid_out, data_out, DW'(i));
      end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%0b exp=1", empty); end
    drive(0, 1, 0, 0, 1, '0);
    total++; if (valid_out !== 1'b0 || data_out !== 16'h0040) begin
      bad++; $display("FAIL underflow got=%b/%h exp=0/0040", valid_out, data_out);
    end
  endtask

  task automatic test_bypass();
    drive(0, 1, 0, 1, 1, 16'h1234);
    total++; if (valid_out !== 1'b1 || data_out !== 16'h1234) begin
      bad++; $display("FAIL bypass_data got=%b/%h exp=1/1234", valid_out, data_out);
    end
    total++; if (count !== '0 || empty !== 1'b1) begin
      bad++; $display("FAIL bypass_state count=%0d empty=%0b exp=0/1", count, empty);
    end
  endtask

  task automatic test_back_to_back();
    drive(0, 1, 0, 1, 0, 16'h000A);
    drive(0, 1, 0, 1, 0, 16'h000B);
    drive(0, 1, 0, 1, 0, 16'h000C);
    for (int i = 0; i < 100; i++) begin
      drive(0, 1, 0, 1, 1, DW'(16'h0100 + i));
      total++; if (valid_out !== 1'b1 || data_out !== exp_dout) begin
        bad++; $display("FAIL stream_data i=%0d got=%b/%h exp=1/%h", i, valid_out, data_out, exp_dout);
      end
      total++; if (count !== 7'd3) begin bad++; $display("FAIL stream_count i=%0d got=%0d exp=3", i, count); end
    end
    while (mq.size() > 0) begin
      drive(0, 1, 0, 0, 1, '0);
      total++; if (valid_out !== 1'b1 || data_out !== exp_dout) begin
        bad++; $display("FAIL stream_tail got=%b/%h exp=1/%h", valid_out, data_out, exp_dout);
      end
    end
  endtask

  task automatic test_flush();
    logic [DW-1:0] held;
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 1, 0, DW'(16'h0500 + i));
    held = exp_dout;
    drive(0, 1, 1, 1, 1, 16'h7777);
    total++; if (count !== '0 || empty !== 1'b1) begin
      bad++; $display("FAIL flush_state count=%0d empty=%0b exp=0/1", count, empty);
    end
    total++; if (valid_out !== 1'b0 || data_out !== held) begin
      bad++; $display("FAIL flush_out got=%b/%h exp=0/%h", valid_out, data_out, held);
    end
    drive(0, 1, 0, 0, 1, '0);
    total++; if (valid_out !== 1'b0 || count !== '0) begin
      bad++; $display("FAIL flush_read got=%b/%0d exp=0/0", valid_out, count);
    end
  endtask

  task automatic test_clken_reset();
    drive(0, 1, 0, 1, 0, 16'h0C01);
    drive(0, 1, 0, 1, 0, 16'h0C02);
    drive(0, 1, 0, 1, 1, 16'h0C03);
    total++; if (valid_out !== 1'b1 || data_out !== 16'h0C01 || count !== 7'd2) begin
      bad++; $display("FAIL clken_setup got=%b/%h/%0d exp=1/0c01/2", valid_out, data_out, count);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, i[0], ~i[0], i[1], 16'hDEAD);
      total++; if (valid_out !== 1'b1 || data_out !== 16'h0C01 || count !== 7'd2) begin
        bad++; $display("FAIL clken_hold i=%0d got=%b/%h/%0d exp=1/0c01/2", i, valid_out, data_out, count);
      end
    end
    drive(0, 1, 0, 0, 1, '0);
    total++; if (valid_out !== 1'b1 || data_out !== 16'h0C02) begin
      bad++; $display("FAIL reenable_read got=%b/%h exp=1/0c02", valid_out, data_out);
    end
    drive(1, 1, 1, 0, 1, '0);
    total++; if (valid_out !== 1'b0 || data_out !== '0 || count !== '0 || empty !== 1'b1 || full !== 1'b0) begin
      bad++; $display("FAIL midread_reset got=%b/%h/%0d/%b/%b exp=0/0000/0/1/0", valid_out, data_out, count, empty, full);
    end
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b0; flush = 1'b0; wen_in = 1'b0; ren_in = 1'b0; data_in = '0;
    exp_dout = '0; exp_valid = 1'b0; exp_count = 0;
    test_reset();
    test_fill_drain();
    test_bypass();
    test_back_to_back();
    test_flush();
    test_clken_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aqed_fifo_dut.md
Name: aqed_fifo_dut

Overview:
- Synchronous single-clock FIFO; the buffer the A-QED monitor checks.
- Write side takes the monitor's injected stream: original, duplicate and other writes.
- Read side returns data with valid_out, empty and full, using the timing the monitor expects: 1-cycle read latency, plus a bypass when empty with simultaneous read and write.
- Gated by clk_en; cleared by flush.

Parameters:
DATA_WIDTH, 16, width of data_in/data_out.
DEPTH, 64, number of entries; power of 2, >= 4.
AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high reset.
clk_en  input  1  global enable; when low, all state holds.
flush  input  1  synchronous clear of contents, qualified by clk_en.
wen_in  input  1  write request.
data_in  input  DATA_WIDTH  write data.
ren_in  input  1  read request.
data_out  output  DATA_WIDTH  registered read data.
valid_out  output  1  registered; data_out carries the result of a read accepted the previous enabled cycle.
empty  output  1  count == 0; combinational from registered count.
full  output  1  count == DEPTH; combinational from registered count.
count  output  AW+1  current occupancy.

Behaviour:
- Reset, priority over everything including clk_en:
  - wr_ptr=0, rd_ptr=0, count=0.
  - data_out=0, valid_out=0.
  - Hence empty=1, full=0.
- Enabled cycle: clk_en=1 and reset=0. When clk_en=0, no register changes; valid_out and data_out hold.
- Flush (enabled cycle, flush=1):
  - Pointers and count go to 0; valid_out goes to 0; data_out holds.
  - wen_in/ren_in are ignored that cycle.
  - Memory contents need not be cleared.
- Write accept: wa = wen_in & ~full & ~flush.
  - Full blocks writes even if a read happens the same cycle.
- Read accept: ra = ren_in & ~flush & (~empty | wen_in).
- Normal read (~empty & ra):
  - data_out <= mem[rd_ptr]; rd_ptr increments mod DEPTH.
  - If wa also: mem[wr_ptr] <= data_in, wr_ptr increments, count unchanged.
- Bypass (empty & wen_in & ren_in, not flushed):
  - data_out <= data_in; valid_out <= 1.
  - Memory, pointers and count unchanged: the word is consumed without being stored.
- Write only (wa & ~ra): mem[wr_ptr] <= data_in, wr_ptr++, count++.
- valid_out <= ra on every enabled cycle, so exactly 1 cycle of latency. The monitor's registered ren together with (~empty | empty&wen&ren) matches this.
- Read while empty without wen_in: ignored; valid_out=0; no pointer change; no underflow.
- Pointers wrap naturally at AW bits.
- count is exact: range 0..DEPTH, never overflows.
- data_out holds its last value whenever valid_out=0.
- Order: strict FIFO; every accepted word emerges exactly once, in write order, no duplication or loss. A-QED relies on this.
- Reset mid-operation: all in-flight data discarded; next cycle the outputs equal the reset values.
- Simultaneous flush and reset: reset wins; result identical.

Test Plan:
1. Reset, then idle 3 cycles:
   - Response: empty=1, full=0, count=0, valid_out=0, data_out=0.
2. Write 0x0001..0x0040 (64 words), then attempt write 0xBEEF with wen_in=1:
   - full=1 after the 64th write; count=64.
   - 0xBEEF is not stored; count stays 64.
   - 64 reads return 0x0001..0x0040 in order, each with valid_out 1 cycle after ren_in.
   - Ends with empty=1.
3. Empty FIFO, wen_in=ren_in=1, data_in=0x1234:
   - Next cycle: valid_out=1, data_out=0x1234.
   - count stays 0; empty stays 1.
4. Hold 3 entries (0xA,0xB,0xC), then 100 cycles of simultaneous wen/ren with an incrementing pattern:
   - count stays 3; output stream = 0xA,0xB,0xC, then the pattern in order.
   - Pointers wrap past 63 with no corruption.
5. 5 entries, flush=1 together with wen_in=ren_in=1:
   - Next cycle: count=0, empty=1, valid_out=0, data_out unchanged.
   - A following read without wen_in gives valid_out=0.
6. 2 entries, clk_en=0 for 4 cycles with wen/ren/flush toggling:
   - No change to count, data_out or valid_out.
   - Re-enable, then reset asserted mid-read: next cycle all outputs equal their reset values.
